// File: rtl/acc_requant_q7p9.sv
// Streaming requantizer: 32-bit accumulator * scale, rounding shift, saturate to Q7.9.
// Optional SAT_COUNT_EN adds a saturating count of clipped outputs (sat_count).
module acc_requant_q7p9 #(
   parameter int unsigned ACC_W   = 32,
   parameter int unsigned SCALE_W = 16,
   parameter int unsigned OUT_W   = 16,
   parameter int unsigned SHIFT_W = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [ACC_W-1:0]   in_acc,
   input  logic [SCALE_W-1:0] cfg_scale,
   input  logic [SHIFT_W-1:0] cfg_shift,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [OUT_W-1:0]   out_x,
   output logic               out_sat
`ifdef SAT_COUNT_EN
   ,
   output logic [15:0]        sat_count
`endif
);

   localparam int unsigned PROD_W = ACC_W + SCALE_W;
   localparam int unsigned RND_W  = PROD_W + 1;
   localparam int unsigned MAX_SH = PROD_W - 1;
   localparam logic signed [RND_W-1:0] OUT_MAX = RND_W'((longint'(1) << (OUT_W - 1)) - 1);
   localparam logic signed [RND_W-1:0] OUT_MIN = RND_W'(-(longint'(1) << (OUT_W - 1)));

   logic                      v1;
   logic                      v2;
   logic                      adv1;
   logic                      adv2;
   logic signed [PROD_W-1:0]  prod1;
   logic [SHIFT_W-1:0]        sh1;

   logic signed [PROD_W-1:0]  prod_c;
   logic [SHIFT_W-1:0]        sh_c;
   logic signed [RND_W-1:0]   rnd_c;
   logic signed [RND_W-1:0]   sum_c;
   logic signed [RND_W-1:0]   r_c;
   logic [OUT_W-1:0]          x_c;
   logic                      sat_c;

   // Elastic stall chain: a stage moves when it is empty or the stage after it moves.
   assign adv2     = ~v2 | out_ready;
   assign adv1     = ~v1 | adv2;
   assign in_ready = adv1;
   assign out_valid = v2;

   // Stage-1 product/shift and stage-2 round-half-up plus clip.
   always_comb begin
      prod_c = PROD_W'($signed(in_acc)) * PROD_W'($signed(cfg_scale));
      sh_c   = (cfg_shift > SHIFT_W'(MAX_SH)) ? SHIFT_W'(MAX_SH) : cfg_shift;
      rnd_c  = '0;
      if (sh1 != '0) begin
         rnd_c = RND_W'(1) << (sh1 - SHIFT_W'(1));
      end
      sum_c  = RND_W'(prod1) + rnd_c;
      r_c    = sum_c >>> sh1;
      x_c    = OUT_W'(r_c);
      sat_c  = 1'b0;
      if (r_c > OUT_MAX) begin
         x_c   = OUT_W'(OUT_MAX);
         sat_c = 1'b1;
      end else if (r_c < OUT_MIN) begin
         x_c   = OUT_W'(OUT_MIN);
         sat_c = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1    <= 1'b0;
         prod1 <= '0;
         sh1   <= '0;
      end else if (adv1) begin
         v1    <= in_valid;
         prod1 <= prod_c;
         sh1   <= sh_c;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v2      <= 1'b0;
         out_x   <= '0;
         out_sat <= 1'b0;
      end else if (adv2) begin
         v2      <= v1;
         out_x   <= x_c;
         out_sat <= sat_c;
      end
   end

`ifdef SAT_COUNT_EN
   // Counts clipped words as they leave; sticks at all-ones.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sat_count <= '0;
      end else if (v2 && out_ready && out_sat && (sat_count != 16'hFFFF)) begin
         sat_count <= sat_count + 16'd1;
      end
   end
`endif

endmodule
